// File: rtl/register_write_arbiter.sv
// Shared-register write arbiter: round-robin grant among NUM_REQS writers,
// with an optional lock that gives one writer exclusive ownership.
module register_write_arbiter #(
  parameter int BIT_WIDTH = 32,
  parameter int NUM_REQS  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           recv_val,
  input  logic [NUM_REQS*BIT_WIDTH-1:0] recv_msg,
  input  logic [NUM_REQS-1:0]           recv_lock,
  output logic [NUM_REQS-1:0]           recv_rdy,
  output logic [BIT_WIDTH-1:0]          q,
  output logic                          q_val,
  output logic [$clog2(NUM_REQS)-1:0]   last_id,
  output logic                          locked
);

  localparam int IDW = $clog2(NUM_REQS);
  localparam logic [IDW:0] N_EXT = (IDW+1)'(NUM_REQS);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       last_id_q, last_id_d;
  logic [BIT_WIDTH-1:0] q_q, q_d;
  logic                 q_val_q, q_val_d;

  logic                 grant_found;
  logic [IDW-1:0]       win_idx;
  logic [IDW-1:0]       ptr_inc;
  logic [IDW:0]         cand;
  logic [BIT_WIDTH-1:0] msg_arr [NUM_REQS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQS; gi++) begin : g_port
      assign msg_arr[gi]  = recv_msg[gi*BIT_WIDTH +: BIT_WIDTH];
      assign recv_rdy[gi] = grant_found && (win_idx == IDW'(gi));
    end
  endgenerate

  // Offsets are scanned from farthest to nearest so the nearest valid
  // requester from ptr overwrites any earlier candidate.
  always_comb begin
    grant_found = 1'b0;
    win_idx     = '0;
    cand        = '0;
    if (state_q == ST_LOCKED) begin
      grant_found = recv_val[ptr_q];
      win_idx     = ptr_q;
    end else begin
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
        cand = {1'b0, ptr_q} + (IDW+1)'(k);
        if (cand >= N_EXT) cand = cand - N_EXT;
        if (recv_val[cand[IDW-1:0]]) begin
          grant_found = 1'b1;
          win_idx     = cand[IDW-1:0];
        end
      end
    end
    if (reset) grant_found = 1'b0;
  end

  assign ptr_inc = (win_idx == IDW'(NUM_REQS - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    last_id_d = last_id_q;
    q_d       = q_q;
    q_val_d   = q_val_q;
    if (grant_found) begin
      q_d       = msg_arr[win_idx];
      q_val_d   = 1'b1;
      last_id_d = win_idx;
      // A locking writer keeps the pointer on itself; that pointer is the owner.
      if (recv_lock[win_idx]) begin
        ptr_d   = win_idx;
        state_d = ST_LOCKED;
      end else begin
        ptr_d   = ptr_inc;
        state_d = ST_UNLOCKED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_UNLOCKED;
      ptr_q     <= '0;
      last_id_q <= '0;
      q_q       <= '0;
      q_val_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      last_id_q <= last_id_d;
      q_q       <= q_d;
      q_val_q   <= q_val_d;
    end
  end

  assign q       = q_q;
  assign q_val   = q_val_q;
  assign last_id = last_id_q;
  assign locked  = (state_q == ST_LOCKED);

endmodule

// File: doc/register_write_arbiter.md
REGISTER_WRITE_ARBITER -- requirements
Module: register_write_arbiter

Interface
REQ-001: Parameter BIT_WIDTH, default 32, width of the shared register and of each request payload.
REQ-002: Parameter NUM_REQS, default 4, number of requesters; legal range 2..8.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: recv_val  input  NUM_REQS  per-requester write-request valid.
REQ-006: recv_msg  input  NUM_REQS*BIT_WIDTH  per-requester write data; requester i occupies bits [i*BIT_WIDTH +: BIT_WIDTH].
REQ-007: recv_lock  input  NUM_REQS  per-requester lock request, sampled only on that requester's transfer.
REQ-008: recv_rdy  output  NUM_REQS  per-requester grant; at most one bit high per cycle.
REQ-009: q  output  BIT_WIDTH  current value of the shared register.
REQ-010: q_val  output  1  high once the register has been written since reset.
REQ-011: last_id  output  clog2(NUM_REQS)  index of the most recent writer.
REQ-012: locked  output  1  high while a requester holds exclusive ownership.

Function
REQ-013: A transfer on port i SHALL occur in a cycle where recv_val[i] and recv_rdy[i] are both high.
REQ-014: recv_rdy SHALL be combinational from recv_val, the priority pointer ptr and the lock state; recv_rdy SHALL NOT depend on recv_msg.
REQ-015: Unlocked: the winner SHALL be the first i with recv_val[i]=1, searching ptr, ptr+1, ..., NUM_REQS-1, 0, ..., ptr-1 (mod NUM_REQS).
REQ-016: Locked: only the lock owner SHALL be eligible; recv_rdy[owner]=recv_val[owner]; all other recv_rdy bits SHALL be 0.
REQ-017: If no eligible requester is valid, recv_rdy SHALL be all zero and all state SHALL hold.
REQ-018: On a transfer from winner w: q <= recv_msg[w], q_val <= 1, last_id <= w; the write is visible on q the cycle after the transfer (latency 1).
REQ-019: On a transfer with recv_lock[w]=0: ptr <= (w+1) mod NUM_REQS; locked <= 0.
REQ-020: On a transfer with recv_lock[w]=1: ptr <= w; locked <= 1 (owner = ptr).
REQ-021: While locked, an owner transfer with recv_lock=0 SHALL release the lock and advance ptr to (owner+1) mod NUM_REQS in the same edge.
REQ-022: While locked and the owner's recv_val=0, no grant SHALL be issued and the lock SHALL persist.
REQ-023: Pointer wrap: from w=NUM_REQS-1, ptr SHALL become 0.
REQ-024: State machine: UNLOCKED and LOCKED; UNLOCKED->LOCKED on a transfer with lock=1; LOCKED->UNLOCKED on an owner transfer with lock=0; no other transitions except reset.
REQ-025: q SHALL change only on a transfer; no partial or merged writes.

Reset
REQ-026: While reset is high, recv_rdy SHALL be all zero and no transfer SHALL occur regardless of recv_val.
REQ-027: On a clock edge with reset high: q=0, q_val=0, last_id=0, ptr=0, locked=0 (state UNLOCKED).
REQ-028: Reset asserted while locked SHALL clear the lock; the first post-reset grant follows REQ-015 from ptr=0.

Verification
REQ-029: After reset, recv_val=4'b1111 held 5 cycles, msg[i]=0x10+i, lock=0 -> grants 0,1,2,3,0; q after each edge 0x10,0x11,0x12,0x13,0x10; q_val=1 from first grant.
REQ-030: ptr=3 (after a grant to 2), recv_val=4'b1001 -> grant 3, then ptr=0, next grant 0 (wrap).
REQ-031: Requester 1 transfers with lock=1 (msg 0xAA), then recv_val=4'b1111 for 3 cycles with lock[1]=1 -> only port 1 granted each cycle, locked=1; then lock[1]=0 transfer -> locked=0, next grant to 2.
REQ-032: Locked to owner 2, recv_val[2]=0, others valid 4 cycles -> recv_rdy=0, q unchanged, locked stays 1.
REQ-033: Assert reset for 1 cycle while locked with all recv_val=1 -> recv_rdy=0 during reset; after: q=0, q_val=0, locked=0, first grant to port 0.
REQ-034: Random recv_val/lock, 10k cycles, against a reference model -> recv_rdy one-hot-or-zero every cycle, q/last_id/locked match model exactly.
